// File: rtl/speed_ce_ctrl.sv
// speed_ce_ctrl: MAC speed-change sequencer. Generates the datapath clock enable and MAC reset.
// Optional quiesce timeout is enabled by defining SPEED_CE_TIMEOUT_EN.
//
// state   | meaning
// HOLD    | Mac_rst asserted, hold counter running down, no clock enables
// RUN     | normal operation at Speed_cur, speed requests accepted
// QUIESCE | change pending, waiting for Tx_idle before switching speed
module speed_ce_ctrl #(
  parameter int RST_HOLD = 16,
  parameter int DIV_100M = 10,
  parameter int DIV_10M  = 100
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Speed_req,
  input  logic       Speed_req_vld,
  output logic       Speed_req_rdy,
  input  logic       Tx_idle,
  output logic       Clk_en,
  output logic       Mac_rst,
  output logic [1:0] Speed_cur,
  output logic       Timeout
);

  localparam logic [1:0] SPD_10M  = 2'b00;
  localparam logic [1:0] SPD_1G   = 2'b10;
  localparam logic [1:0] SPD_RSVD = 2'b11;

  localparam int DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [7:0]       HOLD_INIT     = 8'(RST_HOLD - 1);
  localparam logic [DIV_W-1:0] DIV_100M_LAST = DIV_W'(DIV_100M - 1);
  localparam logic [DIV_W-1:0] DIV_10M_LAST  = DIV_W'(DIV_10M - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_QUIESCE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       speed_cur_q, speed_cur_d;
  logic [1:0]       speed_lat_q, speed_lat_d;
  logic             mac_rst_q, mac_rst_d;
  logic             clk_en_q, clk_en_d;
  logic             rdy_q, rdy_d;

  logic             req_accept;
  logic             req_change;
  logic             quiesce_exit;
  logic             timeout_fire;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] div_next;

  assign req_accept   = Speed_req_vld && rdy_q && (state_q == ST_RUN);
  assign req_change   = req_accept && (Speed_req != speed_cur_q) && (Speed_req != SPD_RSVD);
  assign quiesce_exit = Tx_idle || timeout_fire;

  // Divider keeps running at the old rate through QUIESCE; it idles at 0 in 1000M.
  assign div_last = (speed_cur_q == SPD_10M) ? DIV_10M_LAST : DIV_100M_LAST;
  assign div_next = (speed_cur_q == SPD_1G) ? '0 :
                    (div_cnt_q == div_last) ? '0 : div_cnt_q + 1'b1;

`ifdef SPEED_CE_TIMEOUT_EN
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       timeout_q, timeout_d;

  assign timeout_fire = (state_q == ST_QUIESCE) && !Tx_idle && (to_cnt_q == 10'h3FF);

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_fire;
    if ((state_q == ST_QUIESCE) && (state_d == ST_QUIESCE)) begin
      to_cnt_d = to_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign Timeout      = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= HOLD_INIT;
      div_cnt_q   <= '0;
      speed_cur_q <= SPD_1G;
      speed_lat_q <= SPD_1G;
      mac_rst_q   <= 1'b1;
      clk_en_q    <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      div_cnt_q   <= div_cnt_d;
      speed_cur_q <= speed_cur_d;
      speed_lat_q <= speed_lat_d;
      mac_rst_q   <= mac_rst_d;
      clk_en_q    <= clk_en_d;
      rdy_q       <= rdy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    div_cnt_d   = div_cnt_q;
    speed_cur_d = speed_cur_q;
    speed_lat_d = speed_lat_q;
    case (state_q)
      ST_HOLD: begin
        div_cnt_d = '0;
        if (hold_cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      ST_RUN: begin
        div_cnt_d = div_next;
        if (req_change) begin
          speed_lat_d = Speed_req;
          state_d     = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        div_cnt_d = div_next;
        if (quiesce_exit) begin
          speed_cur_d = speed_lat_q;
          hold_cnt_d  = HOLD_INIT;
          div_cnt_d   = '0;
          state_d     = ST_HOLD;
        end
      end
      default: begin
        hold_cnt_d = HOLD_INIT;
        div_cnt_d  = '0;
        state_d    = ST_HOLD;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    mac_rst_d = (state_d == ST_HOLD);
    rdy_d     = (state_d == ST_RUN);
    clk_en_d  = 1'b0;
    if (state_d != ST_HOLD) begin
      clk_en_d = (speed_cur_d == SPD_1G) || (div_cnt_d == '0);
    end
  end

  assign Speed_req_rdy = rdy_q;
  assign Mac_rst       = mac_rst_q;
  assign Clk_en        = clk_en_q;
  assign Speed_cur     = speed_cur_q;

endmodule

// File: tb/tb_speed_ce_ctrl.sv
// Testbench for speed_ce_ctrl: directed request table, reset/timeout sequences and random traffic
// checked every cycle against a behavioural model.
module tb_speed_ce_ctrl;

  localparam int RST_HOLD = 16;
  localparam int DIV_100M = 10;
  localparam int DIV_10M  = 100;
`ifdef SPEED_CE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int M_HOLD = 0, M_RUN = 1, M_QUIESCE = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] Speed_req = 2'b00;
  logic       Speed_req_vld = 1'b0;
  logic       Speed_req_rdy;
  logic       Tx_idle = 1'b1;
  logic       Clk_en;
  logic       Mac_rst;
  logic [1:0] Speed_cur;
  logic       Timeout;

  speed_ce_ctrl #(
    .RST_HOLD(RST_HOLD),
    .DIV_100M(DIV_100M),
    .DIV_10M (DIV_10M)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Speed_req    (Speed_req),
    .Speed_req_vld(Speed_req_vld),
    .Speed_req_rdy(Speed_req_rdy),
    .Tx_idle      (Tx_idle),
    .Clk_en       (Clk_en),
    .Mac_rst      (Mac_rst),
    .Speed_cur    (Speed_cur),
    .Timeout      (Timeout)
  );

  always #4 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode, cycles left in reset hold, cycles since the divider restarted.
  int m_mode      = M_HOLD;
  int m_hold_left = RST_HOLD;
  int m_run_cyc   = 0;
  int m_speed     = 2;
  int m_pend      = 2;
  int m_qcyc      = 0;
  int m_to        = 0;

  function automatic int period_of(input int sp);
    return (sp == 0) ? DIV_10M : (sp == 1) ? DIV_100M : 1;
  endfunction

  task automatic model_update();
    if (Reset) begin
      m_mode = M_HOLD; m_hold_left = RST_HOLD; m_run_cyc = 0;
      m_speed = 2; m_pend = 2; m_qcyc = 0; m_to = 0;
      return;
    end
    m_to = 0;
    case (m_mode)
      M_HOLD: begin
        if (m_hold_left == 1) begin m_mode = M_RUN; m_run_cyc = 0; end
        else m_hold_left--;
      end
      M_RUN: begin
        m_run_cyc++;
        if (Speed_req_vld && int'(Speed_req) != m_speed && Speed_req != 2'b11) begin
          m_pend = int'(Speed_req); m_mode = M_QUIESCE; m_qcyc = 0;
        end
      end
      default: begin
        m_run_cyc++;
        if (Tx_idle || (TO_EN && m_qcyc == 1023)) begin
          if (!Tx_idle) m_to = 1;
          m_speed = m_pend; m_mode = M_HOLD; m_hold_left = RST_HOLD;
        end else m_qcyc++;
      end
    endcase
  endtask

  task automatic compare_outputs();
    int exp_ce;
    exp_ce = (m_mode != M_HOLD) && (m_speed == 2 || (m_run_cyc % period_of(m_speed)) == 0);
    check("mac_rst", int'(Mac_rst), int'(m_mode == M_HOLD));
    check("rdy", int'(Speed_req_rdy), int'(m_mode == M_RUN));
    check("clk_en", int'(Clk_en), exp_ce);
    check("speed_cur", int'(Speed_cur), m_speed);
    check("timeout", int'(Timeout), m_to);
  endtask

  task automatic step();
    @(posedge Clk);
    model_update();
    @(negedge Clk);
    compare_outputs();
  endtask

  task automatic count_mac_rst(output int h);
    h = 0;
    while (Mac_rst && h < 300) begin h++; step(); end
  endtask

  task automatic measure_period(output int p);
    int n;
    n = 0;
    while (!Clk_en && n < 300) begin step(); n++; end
    step();
    p = 1;
    while (!Clk_en && p < 300) begin step(); p++; end
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!Speed_req_rdy && n < 3000) begin step(); n++; end
    check("rdy_wait", int'(Speed_req_rdy), 1);
  endtask

  typedef struct {
    logic [1:0] req;
    int         delay;
    logic [1:0] exp_speed;
    int         exp_hold;
    int         exp_period;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int h, p, n;
    vecs[0] = '{2'b01,  0, 2'b01, 16,  10};
    vecs[1] = '{2'b00, 50, 2'b00, 16, 100};
    vecs[2] = '{2'b00,  0, 2'b00,  0, 100};
    vecs[3] = '{2'b11,  0, 2'b00,  0, 100};
    vecs[4] = '{2'b10,  3, 2'b10, 16,   1};
    vecs[5] = '{2'b10,  0, 2'b10,  0,   1};
    vecs[6] = '{2'b11,  0, 2'b10,  0,   1};
    vecs[7] = '{2'b01,  7, 2'b01, 16,  10};

    // Reset state and the hold after release.
    Reset = 1'b1;
    repeat (3) step();
    check("rst_mac_rst", int'(Mac_rst), 1);
    check("rst_speed", int'(Speed_cur), 2);
    Reset = 1'b0;
    count_mac_rst(h);
    check("por_hold_len", h, RST_HOLD);
    check("por_first_clk_en", int'(Clk_en), 1);
    measure_period(p);
    check("por_period", p, 1);

    for (int i = 0; i < 8; i++) begin
      wait_rdy();
      Speed_req     = vecs[i].req;
      Speed_req_vld = 1'b1;
      Tx_idle       = (vecs[i].delay == 0);
      step();
      Speed_req_vld = 1'b0;
      Speed_req     = 2'($urandom_range(0, 3));
      h = 0;
      if (vecs[i].exp_hold > 0) begin
        for (int k = 0; k < vecs[i].delay; k++) step();
        check("quiesce_speed_kept", int'(Speed_cur), (i == 0) ? 2 : int'(vecs[i-1].exp_speed));
        Tx_idle = 1'b1;
        n = 0;
        while (!Mac_rst && n < 10) begin step(); n++; end
        count_mac_rst(h);
        check("first_run_clk_en", int'(Clk_en), 1);
      end else begin
        for (int k = 0; k < 5; k++) begin step(); if (Mac_rst) h++; end
      end
      check("vec_hold_len", h, vecs[i].exp_hold);
      check("vec_speed", int'(Speed_cur), int'(vecs[i].exp_speed));
      measure_period(p);
      check("vec_period", p, vecs[i].exp_period);
    end

    // Reset five cycles into HOLD after a 100M request from 1000M.
    wait_rdy();
    Speed_req = 2'b10; Speed_req_vld = 1'b1; step(); Speed_req_vld = 1'b0;
    Tx_idle = 1'b1;
    n = 0; while (!Mac_rst && n < 10) begin step(); n++; end
    count_mac_rst(h);
    wait_rdy();
    Speed_req = 2'b01; Speed_req_vld = 1'b1; step(); Speed_req_vld = 1'b0;
    n = 0; while (!Mac_rst && n < 10) begin step(); n++; end
    repeat (5) step();
    Reset = 1'b1;
    step();
    check("hold_rst_speed", int'(Speed_cur), 2);
    Reset = 1'b0;
    count_mac_rst(h);
    check("hold_rst_len", h, RST_HOLD);
    measure_period(p);
    check("hold_rst_period", p, 1);

    // Reset mid-QUIESCE discards the pending request.
    Speed_req = 2'b00; Speed_req_vld = 1'b1; Tx_idle = 1'b0; step(); Speed_req_vld = 1'b0;
    repeat (10) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    Tx_idle = 1'b1;
    count_mac_rst(h);
    check("quiesce_rst_len", h, RST_HOLD);
    repeat (150) step();
    check("quiesce_rst_speed", int'(Speed_cur), 2);

`ifdef SPEED_CE_TIMEOUT_EN
    Speed_req = 2'b01; Speed_req_vld = 1'b1; Tx_idle = 1'b0; step(); Speed_req_vld = 1'b0;
    n = 0;
    while (!Mac_rst && n < 1100) begin step(); n++; end
    check("to_quiesce_len", n, 1024);
    check("to_pulse", int'(Timeout), 1);
    step();
    check("to_pulse_len", int'(Timeout), 0);
    Tx_idle = 1'b1;
    wait_rdy();
    Speed_req = 2'b00; Speed_req_vld = 1'b1; Tx_idle = 1'b0; step(); Speed_req_vld = 1'b0;
    repeat (1023) step();
    Tx_idle = 1'b1;
    step();
    check("idle_1024_hold", int'(Mac_rst), 1);
    check("idle_1024_no_to", int'(Timeout), 0);
`else
    Speed_req = 2'b01; Speed_req_vld = 1'b1; Tx_idle = 1'b0; step(); Speed_req_vld = 1'b0;
    h = 0; n = 0;
    for (int k = 0; k < 5000; k++) begin step(); if (Mac_rst) h++; if (Timeout) n++; end
    check("no_to_hold", h, 0);
    check("no_to_pulse", n, 0);
    check("no_to_speed", int'(Speed_cur), 2);
    Tx_idle = 1'b1;
`endif
    step();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      Speed_req     = 2'($urandom_range(0, 3));
      Speed_req_vld = ($urandom_range(0, 9) < 3);
      Tx_idle       = ($urandom_range(0, 9) < 7);
      Reset         = ($urandom_range(0, 499) == 0);
      step();
    end
    Reset = 1'b0; Speed_req_vld = 1'b0; Tx_idle = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/speed_ce_ctrl.md
SPEED_CE_CTRL -- requirements
Module: speed_ce_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD, default 16: cycles Mac_rst is held high after reset release or a speed change (legal 2..255).
REQ-002 SHALL have parameter DIV_100M, default 10: Clk cycles per Clk_en pulse in 100M mode.
REQ-003 SHALL have parameter DIV_10M, default 100: Clk cycles per Clk_en pulse in 10M mode.
REQ-004 SHALL have port Clk  input  1  single 125 MHz clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Speed_req  input  2  requested speed: 00=10M, 01=100M, 10=1000M, 11=reserved.
REQ-007 SHALL have port Speed_req_vld  input  1  request valid; held until accepted.
REQ-008 SHALL have port Speed_req_rdy  output  1  request accepted when vld and rdy are high on the same edge.
REQ-009 SHALL have port Tx_idle  input  1  MAC datapath idle indication.
REQ-010 SHALL have port Clk_en  output  1  datapath clock-enable pulse.
REQ-011 SHALL have port Mac_rst  output  1  active-high synchronous reset to MAC domains.
REQ-012 SHALL have port Speed_cur  output  2  speed currently in effect, same encoding as Speed_req.
REQ-013 SHALL have port Timeout  output  1  one-cycle pulse on quiesce timeout (see Configuration).

Function
- FSM states HOLD, RUN, QUIESCE; all outputs registered.
REQ-014 In HOLD, Mac_rst=1, Clk_en=0, Speed_req_rdy=0; the 8-bit hold counter decrements each cycle, and at 0 the FSM goes to RUN.
REQ-015 In RUN, Mac_rst=0 and Speed_req_rdy=1.
REQ-016 On entry to RUN the divider counter SHALL be 0, so the first Clk_en=1 occurs in the first RUN cycle.
REQ-017 In RUN at 1000M, Clk_en SHALL be constant 1.
REQ-018 In RUN at 100M/10M, the divider counts 0..DIV-1, wraps to 0, and Clk_en=1 exactly when it is 0 (one pulse per DIV cycles, duty 1/DIV).
REQ-019 On acceptance of Speed_req equal to Speed_cur or 11, the request is consumed with no other effect; the divider phase is undisturbed.
REQ-020 On acceptance of a different legal Speed_req, the new value SHALL be latched and the FSM goes to QUIESCE next cycle.
REQ-021 In QUIESCE, Speed_req_rdy=0, Mac_rst=0, and Clk_en continues at the old speed.
REQ-022 In QUIESCE, on the first cycle Tx_idle=1, Speed_cur SHALL take the latched value, the hold counter loads RST_HOLD-1, the divider clears, and the FSM goes to HOLD.
REQ-023 Speed_cur SHALL change only on the QUIESCE->HOLD transition, never while Mac_rst=0.
REQ-024 Changes of Speed_req while Speed_req_vld=0, or while not in RUN, SHALL be ignored.

Reset
REQ-025 While Reset=1: state=HOLD, hold counter=RST_HOLD-1, divider=0, Speed_cur=10, Mac_rst=1, Clk_en=0, Speed_req_rdy=0, Timeout=0.
REQ-026 After Reset falls, Mac_rst SHALL stay high for exactly RST_HOLD cycles; the first RUN cycle follows.
REQ-027 Reset asserted in any state, including mid-QUIESCE or mid-HOLD, SHALL abort the operation immediately and discard any latched request; Speed_cur returns to 10.

Configuration
REQ-028 With macro SPEED_CE_TIMEOUT_EN defined, a 10-bit counter SHALL run in QUIESCE.
REQ-029 If 1024 QUIESCE cycles elapse without Tx_idle=1, the block SHALL perform the REQ-022 transition and pulse Timeout for 1 cycle.
REQ-030 Tx_idle=1 on the 1024th cycle SHALL count as idle, with no Timeout pulse.
REQ-031 Without SPEED_CE_TIMEOUT_EN, QUIESCE waits indefinitely for Tx_idle, and Timeout is tied to 0.

Verification
REQ-032 Reset pulse, Tx_idle=1 -> Mac_rst high 16 cycles after release; Speed_cur=10; Clk_en=1 every cycle after.
REQ-033 From 1000M, request 01 with Tx_idle=1 -> rdy low, 16-cycle Mac_rst, Speed_cur=01, then Clk_en pulses at cycles 0,10,20 of RUN.
REQ-034 Request 00 with Tx_idle=0 for 50 cycles -> Clk_en keeps old rate, Speed_cur unchanged until Tx_idle rises, then period is 100.
REQ-035 Request 10 while at 10 and request 11 -> each accepted in 1 cycle; Mac_rst stays 0; Clk_en phase unchanged.
REQ-036 Reset asserted 5 cycles into HOLD after a 01 request -> Speed_cur=10 and a full 16-cycle hold follows release.
REQ-037 With SPEED_CE_TIMEOUT_EN, Tx_idle stuck at 0 -> Timeout pulse at QUIESCE cycle 1024, then HOLD; without the macro, the FSM stays in QUIESCE for 5000 cycles.
